// File: rtl/memory_cycle.sv
// memory_cycle: memory stage of a 5-stage RV32I pipeline.
// Word-addressed data memory (combinational read, synchronous write) and
// the M/W pipeline register that feeds writeback.
// Optional build macro: DMEM_MISALIGN_CHK_EN adds a MisalignW output and
// suppresses stores whose byte address is not word aligned.
module memory_cycle #(
   parameter int DMEM_WORDS = 1024,
   parameter int DMEM_AW    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
`ifdef DMEM_MISALIGN_CHK_EN
   output logic        MisalignW,
`endif
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW
);

   // Data memory; contents survive reset. Word 0x10 (byte 0x40) is preloaded.
   logic [31:0] mem_q [DMEM_WORDS] = '{16: 32'hCAFEBABE, default: 32'h0};

   logic [DMEM_AW-1:0] word_idx;
   logic [31:0]        rd_data;
   logic               misaligned;
   logic               mem_we;

   // Upper address bits and the byte offset do not take part in indexing.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, ALU_ResultM[31:DMEM_AW+2], ALU_ResultM[1:0]};

   assign word_idx   = ALU_ResultM[DMEM_AW+1:2];
   assign misaligned = |ALU_ResultM[1:0];
   // Combinational read: a same-cycle write lands at the edge, so a colliding
   // read sees the old contents.
   assign rd_data    = mem_q[word_idx];

`ifdef DMEM_MISALIGN_CHK_EN
   assign mem_we = MemWriteM & ~rst & ~misaligned;
`else
   assign mem_we = MemWriteM & ~rst;
   logic unused_misaligned;
   assign unused_misaligned = misaligned;
`endif

   logic        reg_write_q;
   logic        result_src_q;
   logic [4:0]  rd_q;
   logic [31:0] pc_plus4_q;
   logic [31:0] alu_result_q;
   logic [31:0] read_data_q;
`ifdef DMEM_MISALIGN_CHK_EN
   logic        misalign_q;
`endif

   // Synchronous memory write; stores during reset are dropped.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_idx] <= WriteDataM;
      end
   end

   // M/W pipeline register: no enable, no flush, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= 5'd0;
         pc_plus4_q   <= 32'd0;
         alu_result_q <= 32'd0;
         read_data_q  <= 32'd0;
`ifdef DMEM_MISALIGN_CHK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         reg_write_q  <= RegWriteM;
         result_src_q <= ResultSrcM;
         rd_q         <= RD_M;
         pc_plus4_q   <= PCPlus4M;
         alu_result_q <= ALU_ResultM;
         read_data_q  <= rd_data;
`ifdef DMEM_MISALIGN_CHK_EN
         misalign_q   <= (MemWriteM | ResultSrcM) & misaligned;
`endif
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign RD_W        = rd_q;
   assign PCPlus4W    = pc_plus4_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;
`ifdef DMEM_MISALIGN_CHK_EN
   assign MisalignW   = misalign_q;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Testbench for memory_cycle: directed vectors, expected W-stage values are
// queued by the driver and checked by an independent monitor one edge later.
module tb_memory_cycle;

   logic        clk;
   logic        rst;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
   logic        RegWriteW, ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef DMEM_MISALIGN_CHK_EN
   logic        MisalignW;
`endif

   typedef struct {
      logic        rw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   memory_cycle dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .RD_M       (RD_M),
      .PCPlus4M   (PCPlus4M),
      .WriteDataM (WriteDataM),
      .ALU_ResultM(ALU_ResultM),
`ifdef DMEM_MISALIGN_CHK_EN
      .MisalignW  (MisalignW),
`endif
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .RD_W       (RD_W),
      .PCPlus4W   (PCPlus4W),
      .ALU_ResultW(ALU_ResultW),
      .ReadDataW  (ReadDataW)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Driver: present one instruction for one edge and queue its expected result.
   task automatic apply(input logic r, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [31:0] e_rdata, input logic e_mis);
      exp_t e;
      @(negedge clk);
      rst = r; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
      RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
      if (r) begin
         e = '{rw: 1'b0, rs: 1'b0, rd: 5'd0, pc: 32'd0, alu: 32'd0, rdata: 32'd0, mis: 1'b0};
      end else begin
         e = '{rw: rw, rs: rs, rd: rd, pc: pc, alu: alu, rdata: e_rdata, mis: e_mis};
      end
      exp_q.push_back(e);
   endtask

   // Monitor: one queued expectation per rising edge, sampled just after it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         check("RegWriteW",   {31'd0, RegWriteW},  {31'd0, e.rw});
         check("ResultSrcW",  {31'd0, ResultSrcW}, {31'd0, e.rs});
         check("RD_W",        {27'd0, RD_W},       {27'd0, e.rd});
         check("PCPlus4W",    PCPlus4W,            e.pc);
         check("ALU_ResultW", ALU_ResultW,         e.alu);
         check("ReadDataW",   ReadDataW,           e.rdata);
`ifdef DMEM_MISALIGN_CHK_EN
         check("MisalignW",   {31'd0, MisalignW},  {31'd0, e.mis});
`endif
      end
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0;
      RD_M = 5'd0; PCPlus4M = 32'd0; WriteDataM = 32'd0; ALU_ResultM = 32'd0;

      //     rst  rw   mw   rs   rd     pc      wd            alu           rdata         mis
      // reset with a store of 0 to 0x40 held for two edges: store dropped
      apply(1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00, 32'h0,        32'h40,       32'h0,        1'b0);
      apply(1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00, 32'h0,        32'h40,       32'h0,        1'b0);
      // load from 0x40: preloaded word survives reset
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA4, 32'h0,        32'h40,       32'hCAFEBABE, 1'b0);
      // store to 0x44: colliding read returns old contents (0)
      apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'hA8, 32'h12345678, 32'h44,       32'h0,        1'b0);
      // load from 0x44 in the following cycle sees the new value
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'hAC, 32'h0,        32'h44,       32'h12345678, 1'b0);
      // ALU pass-through, wrapped index 0x3BB reads 0
      apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'hB0, 32'h0,        32'hBEEFBEEF, 32'h0,        1'b0);
      // store to 0x1044 wraps onto word 0x11 (old value visible this cycle)
      apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'hB4, 32'hA5A5A5A5, 32'h1044,     32'h12345678, 1'b0);
      // load from 0x44
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd13, 32'hB8, 32'h0,        32'h44,       32'hA5A5A5A5, 1'b0);
      // reset mid-operation with a store of 0 to 0x44: dropped, outputs cleared
      apply(1'b1, 1'b1, 1'b1, 1'b1, 5'd14, 32'hBC, 32'h0,        32'h44,       32'h0,        1'b0);
      // load from 0x44 after reset: contents preserved
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd15, 32'hC0, 32'h0,        32'h44,       32'hA5A5A5A5, 1'b0);
      // misaligned store to 0x46, read returns current word 0x11
      apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'hC4, 32'hDEADBEEF, 32'h46,       32'hA5A5A5A5, 1'b1);
`ifdef DMEM_MISALIGN_CHK_EN
      // store was suppressed: prior contents remain
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 32'hC8, 32'h0,        32'h44,       32'hA5A5A5A5, 1'b0);
`else
      // store wrote the aligned word
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 32'hC8, 32'h0,        32'h44,       32'hDEADBEEF, 1'b0);
`endif
      // misaligned load from 0x42 reads word 0x10
      apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd17, 32'hCC, 32'h0,        32'h42,       32'hCAFEBABE, 1'b1);
      // ALU op with a misaligned-looking result is not flagged
      apply(1'b0, 1'b1, 1'b0, 1'b0, 5'd18, 32'hD0, 32'h0,        32'h3,        32'h0,        1'b0);

      // drain the scoreboard with a bounded wait
      begin
         int budget;
         budget = 0;
         while (exp_q.size() > 0 && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
         end
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
